// File: rtl/arb_mux.sv
// arb_mux: registered N-input packet multiplexer with valid/ready handshakes.
// A round-robin arbiter picks one input channel and stays locked to it until
// the last beat of its packet has been accepted. A forced-select mode bypasses
// the round-robin search. Every beat passes through a single output register,
// so the mux runs at one beat per cycle when downstream never stalls.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   per-channel beat valid
//   in_ready   per-channel beat accepted (valid & ready)
//   in_data    packed channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last    per-channel last beat of packet
//   force_en   1 = grant only force_sel
//   force_sel  channel granted while force_en = 1
//   out_valid  registered output beat valid
//   out_ready  downstream accepts beat
//   out_data   registered beat data
//   out_last   registered last flag
//   out_sel    source channel of the current output beat
module arb_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  localparam int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_last,
  input  logic                         force_en,
  input  logic [SEL_W-1:0]             force_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [SEL_W-1:0]             out_sel
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state;
  logic [SEL_W-1:0]        grant;
  logic [SEL_W-1:0]        ptr;
  logic                    forced;

  logic                    can_accept;
  logic                    accept;
  logic                    g_valid;
  logic                    g_last;
  logic [DATA_WIDTH-1:0]   g_data;

  logic                    hi_found;
  logic                    lo_found;
  logic [SEL_W-1:0]        hi_idx;
  logic [SEL_W-1:0]        lo_idx;
  logic                    rr_found;
  logic [SEL_W-1:0]        rr_winner;
  logic                    force_ok;
  logic [SEL_W-1:0]        ptr_next;

  // The output register can take a new beat when empty or draining this cycle.
  assign can_accept = !out_valid || out_ready;

  // Granted-channel selection. in_ready depends only on state, grant and the
  // output register, never on in_valid.
  always_comb begin
    in_ready = '0;
    g_valid  = 1'b0;
    g_data   = '0;
    g_last   = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = (state == LOCKED) && can_accept;
        g_valid     = in_valid[i];
        g_data      = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        g_last      = in_last[i];
      end
    end
  end

  assign accept = (state == LOCKED) && can_accept && g_valid;

  // Round-robin search: the lowest valid index at or above ptr wins; if there
  // is none, the lowest valid index below ptr wins (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_valid[i]) begin
        if (SEL_W'(i) >= ptr) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = SEL_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = SEL_W'(i);
        end
      end
    end
    rr_found  = hi_found || lo_found;
    rr_winner = hi_found ? hi_idx : lo_idx;
  end

  // Out-of-range force_sel values match no channel and so never grant.
  always_comb begin
    force_ok = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (force_sel == SEL_W'(i) && in_valid[i]) begin
        force_ok = 1'b1;
      end
    end
  end

  assign ptr_next = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      forced    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_last  <= g_last;
        out_sel   <= grant;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (force_en) begin
            if (force_ok) begin
              grant  <= force_sel;
              forced <= 1'b1;
              state  <= LOCKED;
            end
          end else if (rr_found) begin
            grant  <= rr_winner;
            forced <= 1'b0;
            state  <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && g_last) begin
            state <= IDLE;
            // Forced packets do not disturb round-robin fairness.
            if (!forced) begin
              ptr <= ptr_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a 4-input instance checked through an output scoreboard,
// plus a 5-input instance for out-of-range forcing and non-power-of-two wrap.
module tb_arb_mux;

  logic         clk = 1'b0;
  logic         rst;

  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_last;
  logic         force_en;
  logic [1:0]   force_sel;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   out_sel;

  logic [4:0]   v5;
  logic [4:0]   r5;
  logic [159:0] d5;
  logic [4:0]   l5;
  logic         fe5;
  logic [2:0]   fs5;
  logic         ov5;
  logic         or5;
  logic [31:0]  od5;
  logic         ol5;
  logic [2:0]   os5;

  logic         v_ch[4];
  logic [31:0]  d_ch[4];
  logic         l_ch[4];
  logic         abort;

  logic [63:0]  exp_q[$];
  int           n_cmp = 0;
  int           n_mis = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]          = v_ch[i];
      in_last[i]           = l_ch[i];
      in_data[i*32 +: 32]  = d_ch[i];
    end
  end

  arb_mux #(.DATA_WIDTH(32), .NUM_IN(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  arb_mux #(.DATA_WIDTH(32), .NUM_IN(5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v5),
    .in_ready  (r5),
    .in_data   (d5),
    .in_last   (l5),
    .force_en  (fe5),
    .force_sel (fs5),
    .out_valid (ov5),
    .out_ready (or5),
    .out_data  (od5),
    .out_last  (ol5),
    .out_sel   (os5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_push(input int sel, input bit last, input logic [31:0] data);
    logic [1:0] s;
    s = sel[1:0];
    exp_q.push_back({30'b0, s, last, data});
  endtask

  // Output scoreboard: a beat transfers at the next rising edge whenever
  // out_valid & out_ready are seen here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_beat", {out_sel, out_last, out_data}, 64'd0);
      end else begin
        chk("sb_beat", {out_sel, out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  // One packet on one channel; every beat waits for its handshake.
  task automatic send_pkt(input int ch, input int n, input logic [31:0] base);
    for (int b = 0; b < n && !abort; b++) begin
      int waited;
      bit done;
      waited = 0;
      done   = 0;
      v_ch[ch] = 1'b1;
      d_ch[ch] = base + 32'(b);
      l_ch[ch] = (b == n - 1);
      while (!done) begin
        @(negedge clk);
        if (abort) begin
          done = 1;
        end else if (in_ready[ch]) begin
          done = 1;
        end else if (waited > 300) begin
          chk("hs_timeout", {63'b0, in_ready[ch]}, 64'd1);
          done = 1;
        end
        waited++;
        @(posedge clk);
        #1;
      end
    end
    v_ch[ch] = 1'b0;
    l_ch[ch] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    abort     = 1'b0;
    force_en  = 1'b0;
    force_sel = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v_ch[i] = 1'b0;
      d_ch[i] = '0;
      l_ch[i] = 1'b0;
    end
    v5  = '0;
    d5  = '0;
    l5  = '0;
    fe5 = 1'b0;
    fs5 = '0;
    or5 = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready",  {60'b0, in_ready},  64'd0);
    chk("rst_out_data",  {32'b0, out_data},  64'd0);
    chk("rst_out_last",  {63'b0, out_last},  64'd0);
    chk("rst_out_sel",   {62'b0, out_sel},   64'd0);
    chk("rst5_ready",    {59'b0, r5},        64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // single channel, 3-beat packet on ch2
    exp_push(2, 0, 32'hA1);
    exp_push(2, 0, 32'hA2);
    exp_push(2, 1, 32'hA3);
    fork
      send_pkt(2, 3, 32'hA1);
      begin
        @(negedge clk);
        chk("arb_cycle_ready", {60'b0, in_ready}, 64'd0);
        @(negedge clk);
        chk("arb_latency_ready", {60'b0, in_ready}, 64'h4);
      end
    join
    drain("single_drain");

    // round-robin, all channels valid, 1-beat packets; ptr starts at 3
    exp_push(3, 1, 32'h30); exp_push(0, 1, 32'h00);
    exp_push(1, 1, 32'h10); exp_push(2, 1, 32'h20);
    exp_push(3, 1, 32'h31); exp_push(0, 1, 32'h01);
    exp_push(1, 1, 32'h11); exp_push(2, 1, 32'h21);
    fork
      begin send_pkt(0, 1, 32'h00); send_pkt(0, 1, 32'h01); end
      begin send_pkt(1, 1, 32'h10); send_pkt(1, 1, 32'h11); end
      begin send_pkt(2, 1, 32'h20); send_pkt(2, 1, 32'h21); end
      begin send_pkt(3, 1, 32'h30); send_pkt(3, 1, 32'h31); end
    join
    drain("rr_drain");

    // packet lock: ch1 arrives during ch0's packet
    exp_push(0, 0, 32'h100); exp_push(0, 0, 32'h101);
    exp_push(0, 0, 32'h102); exp_push(0, 1, 32'h103);
    exp_push(1, 1, 32'h200);
    fork
      send_pkt(0, 4, 32'h100);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_pkt(1, 1, 32'h200);
      end
    join
    drain("lock_drain");

    // forced select ch3 with ch1 also valid; ptr (2) must not move
    force_en  = 1'b1;
    force_sel = 2'd3;
    exp_push(3, 1, 32'h400);
    exp_push(3, 1, 32'h401);
    exp_push(1, 1, 32'h410);
    fork
      begin
        send_pkt(3, 1, 32'h400);
        force_en = 1'b0;
        send_pkt(3, 1, 32'h401);
      end
      send_pkt(1, 1, 32'h410);
    join
    drain("force_drain");

    // asynchronous reset in the middle of a 4-beat packet
    exp_push(2, 0, 32'h500); exp_push(2, 0, 32'h501);
    exp_push(2, 0, 32'h502); exp_push(2, 1, 32'h503);
    fork
      send_pkt(2, 4, 32'h500);
      begin
        repeat (3) @(posedge clk);
        #2;
        rst   = 1'b1;
        abort = 1'b1;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_in_ready",  {60'b0, in_ready},  64'd0);
        chk("arst_out_data",  {32'b0, out_data},  64'd0);
      end
    join
    exp_q.delete();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    abort = 1'b0;
    exp_push(1, 1, 32'h600);
    exp_push(2, 1, 32'h610);
    exp_push(3, 1, 32'h620);
    fork
      send_pkt(1, 1, 32'h600);
      send_pkt(2, 1, 32'h610);
      send_pkt(3, 1, 32'h620);
    join
    drain("post_rst_drain");

    // backpressure for 5 cycles in the middle of a packet
    exp_push(3, 0, 32'h300); exp_push(3, 0, 32'h301);
    exp_push(3, 0, 32'h302); exp_push(3, 1, 32'h303);
    fork
      send_pkt(3, 4, 32'h300);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
          chk("bp_out_data",  {32'b0, out_data},  64'h301);
          chk("bp_in_ready",  {60'b0, in_ready},  64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // 5-input instance: out-of-range force_sel never grants
    fe5 = 1'b1;
    fs5 = 3'd5;
    v5  = 5'b11111;
    l5  = 5'b11111;
    d5[4*32 +: 32] = 32'h44;
    repeat (2) begin
      @(negedge clk);
      chk("n5_force_oor_ready", {59'b0, r5},  64'd0);
      chk("n5_force_oor_valid", {63'b0, ov5}, 64'd0);
    end
    @(posedge clk);
    #1;
    fe5 = 1'b0;
    v5  = 5'b10000;
    @(negedge clk);
    @(negedge clk);
    chk("n5_grant_ch4", {59'b0, r5}, 64'h10);
    @(posedge clk);
    #1;
    v5 = 5'b10001;
    @(negedge clk);
    chk("n5_out_sel",  {61'b0, os5}, 64'd4);
    chk("n5_out_data", {32'b0, od5}, 64'h44);
    @(negedge clk);
    chk("n5_ptr_wrap", {59'b0, r5}, 64'h01);
    @(posedge clk);
    #1 v5 = '0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
